// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: power on/off, start/pause, and a
// per-stage countdown through the wash -> rinse -> spin stages.
// Optional macro DOOR_LOCK_EN adds a door_open input that forces and holds pause.
module wash_sequencer #(
  parameter int WASH_T  = 5,
  parameter int RINSE_T = 3,
  parameter int SPIN_T  = 2,
  parameter int CNT_W   = 6
) (
  input  logic             clk_n,
  input  logic             rst,
  input  logic             power_key,
  input  logic             start_pause,
  input  logic [1:0]       mode,
`ifdef DOOR_LOCK_EN
  input  logic             door_open,
`endif
  output logic             power_led,
  output logic             pause,
  output logic             finish,
  output logic             busy,
  output logic [2:0]       stage,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       mode_reg, mode_next;
  logic [CNT_W-1:0] rem_reg, rem_next;
  logic             pause_reg, pause_next;
  logic             finish_reg, finish_next;
  logic             power_led_reg, power_led_next;
  logic             busy_reg, busy_next;
  logic [2:0]       stage_reg, stage_next;
  logic             door_held;

`ifdef DOOR_LOCK_EN
  assign door_held = door_open;
`else
  assign door_held = 1'b0;
`endif

  // Length of a stage in ticks; non-running states have no countdown.
  function automatic logic [CNT_W-1:0] stage_len(input state_t s);
    case (s)
      ST_WASH:  stage_len = CNT_W'(WASH_T);
      ST_RINSE: stage_len = CNT_W'(RINSE_T);
      ST_SPIN:  stage_len = CNT_W'(SPIN_T);
      default:  stage_len = '0;
    endcase
  endfunction

  // First stage of each program.
  function automatic state_t first_stage(input logic [1:0] m);
    case (m)
      2'b00, 2'b01: first_stage = ST_WASH;
      2'b10:        first_stage = ST_RINSE;
      default:      first_stage = ST_SPIN;
    endcase
  endfunction

  // Stage following the current one for the latched program; IDLE means done.
  function automatic state_t next_stage(input state_t s, input logic [1:0] m);
    case (s)
      ST_WASH:  next_stage = ST_RINSE;
      ST_RINSE: next_stage = (m == 2'b00 || m == 2'b10) ? ST_SPIN : ST_IDLE;
      default:  next_stage = ST_IDLE;
    endcase
  endfunction

  // Next-state and next-output decode; all outputs are registered from these.
  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    rem_next    = rem_reg;
    pause_next  = pause_reg;
    finish_next = 1'b0;
    case (state_reg)
      ST_OFF: begin
        pause_next = 1'b0;
        rem_next   = '0;
        if (power_key) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        pause_next = 1'b0;
        rem_next   = '0;
        if (power_key) begin
          state_next = ST_OFF;
        end else if (start_pause && !door_held) begin
          mode_next  = mode;
          state_next = first_stage(mode);
          rem_next   = stage_len(first_stage(mode));
        end
      end
      ST_WASH, ST_RINSE, ST_SPIN: begin
        if (power_key) begin
          state_next = ST_OFF;
          pause_next = 1'b0;
          rem_next   = '0;
        end else if (door_held && !pause_reg) begin
          // Opening the door freezes the run on this edge without counting.
          pause_next = 1'b1;
        end else if (start_pause) begin
          // Toggle edges never count; an open door keeps pause asserted.
          if (!(pause_reg && door_held)) pause_next = !pause_reg;
        end else if (!pause_reg) begin
          if (rem_reg > CNT_W'(1)) begin
            rem_next = rem_reg - CNT_W'(1);
          end else begin
            state_next = next_stage(state_reg, mode_reg);
            rem_next   = stage_len(next_stage(state_reg, mode_reg));
            if (next_stage(state_reg, mode_reg) == ST_IDLE) finish_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_OFF;
        pause_next = 1'b0;
        rem_next   = '0;
      end
    endcase

    power_led_next = (state_next != ST_OFF);
    case (state_next)
      ST_WASH:  stage_next = 3'b001;
      ST_RINSE: stage_next = 3'b010;
      ST_SPIN:  stage_next = 3'b100;
      default:  stage_next = 3'b000;
    endcase
    busy_next = (stage_next != 3'b000);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_n) begin
    if (rst) begin
      state_reg     <= ST_OFF;
      mode_reg      <= 2'b00;
      rem_reg       <= '0;
      pause_reg     <= 1'b0;
      finish_reg    <= 1'b0;
      power_led_reg <= 1'b0;
      busy_reg      <= 1'b0;
      stage_reg     <= 3'b000;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      rem_reg       <= rem_next;
      pause_reg     <= pause_next;
      finish_reg    <= finish_next;
      power_led_reg <= power_led_next;
      busy_reg      <= busy_next;
      stage_reg     <= stage_next;
    end
  end

  assign power_led = power_led_reg;
  assign pause     = pause_reg;
  assign finish    = finish_reg;
  assign busy      = busy_reg;
  assign stage     = stage_reg;
  assign remaining = rem_reg;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed self-checking bench for wash_sequencer (default parameters).
module tb_wash_sequencer;

  logic       clk_n = 1'b0;
  logic       rst = 1'b1;
  logic       power_key = 1'b0;
  logic       start_pause = 1'b0;
  logic [1:0] mode = 2'b00;
`ifdef DOOR_LOCK_EN
  logic       door_open = 1'b0;
`endif
  logic       power_led, pause, finish, busy;
  logic [2:0] stage;
  logic [5:0] remaining;

  int n_checks = 0;
  int n_fail   = 0;

  wash_sequencer dut (
    .clk_n(clk_n),
    .rst(rst),
    .power_key(power_key),
    .start_pause(start_pause),
    .mode(mode),
`ifdef DOOR_LOCK_EN
    .door_open(door_open),
`endif
    .power_led(power_led),
    .pause(pause),
    .finish(finish),
    .busy(busy),
    .stage(stage),
    .remaining(remaining)
  );

  always #5 clk_n = ~clk_n;

  // Advance one rising edge; inputs change and outputs are sampled 1 after it.
  task automatic tick();
    @(posedge clk_n);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_run(input string tag, input logic [2:0] st, input logic [5:0] rem);
    check({tag, ".stage"}, 32'(stage), 32'(st));
    check({tag, ".remaining"}, 32'(remaining), 32'(rem));
    check({tag, ".busy"}, 32'(busy), 32'(st != 3'b000));
  endtask

  // One-cycle start_pause pulse.
  task automatic press_start();
    start_pause = 1'b1;
    tick();
    start_pause = 1'b0;
  endtask

  logic [2:0] exp_stage [10] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4, 3'd4};
  logic [5:0] exp_rem   [10] = '{6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd3, 6'd2, 6'd1, 6'd2, 6'd1};

  initial begin
    // 1: reset
    #1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst.power_led", 32'(power_led), 0);
    check("rst.finish", 32'(finish), 0);
    check("rst.pause", 32'(pause), 0);
    check_run("rst", 3'b000, 6'd0);
    $display("reset: power_led=%0d stage=%0d remaining=%0d", power_led, stage, remaining);

    // start_pause in OFF is ignored
    press_start();
    check("off_start.power_led", 32'(power_led), 0);
    check_run("off_start", 3'b000, 6'd0);

    // power on
    power_key = 1'b1;
    tick();
    power_key = 1'b0;
    check("pwr_on.power_led", 32'(power_led), 1);
    check_run("pwr_on", 3'b000, 6'd0);
    $display("power on: power_led=%0d", power_led);

    // 2: full program, mode 00
    mode = 2'b00;
    press_start();
    mode = 2'b11;  // changes during a run are ignored
    check_run("m00[0]", exp_stage[0], exp_rem[0]);
    for (int i = 1; i < 10; i++) begin
      tick();
      check_run($sformatf("m00[%0d]", i), exp_stage[i], exp_rem[i]);
      check($sformatf("m00[%0d].finish", i), 32'(finish), 0);
    end
    tick();
    check("m00.finish", 32'(finish), 1);
    check_run("m00.done", 3'b000, 6'd0);
    check("m00.power_led", 32'(power_led), 1);
    tick();
    check("m00.finish_off", 32'(finish), 0);
    $display("mode 00 run complete");

    // 3: mode 11
    mode = 2'b11;
    press_start();
    check_run("m11[0]", 3'b100, 6'd2);
    tick();
    check_run("m11[1]", 3'b100, 6'd1);
    tick();
    check("m11.finish", 32'(finish), 1);
    check_run("m11.done", 3'b000, 6'd0);
    tick();
    check("m11.finish_off", 32'(finish), 0);
    $display("mode 11 run complete");

    // 3: mode 10
    mode = 2'b10;
    press_start();
    check_run("m10[0]", 3'b010, 6'd3);
    for (int i = 1; i < 5; i++) begin
      tick();
      check($sformatf("m10[%0d].finish", i), 32'(finish), 0);
    end
    check_run("m10[4]", 3'b100, 6'd1);
    tick();
    check("m10.finish", 32'(finish), 1);
    $display("mode 10 run complete");

    // 4: pause at WASH remaining 3
    mode = 2'b00;
    press_start();
    tick();
    tick();
    check_run("pz.before", 3'b001, 6'd3);
    press_start();
    check("pz.set", 32'(pause), 1);
    check_run("pz.set", 3'b001, 6'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("pz.hold%0d.pause", i), 32'(pause), 1);
      check($sformatf("pz.hold%0d.rem", i), 32'(remaining), 3);
    end
    press_start();
    check("pz.resume", 32'(pause), 0);
    check_run("pz.resume", 3'b001, 6'd3);
    tick();
    check_run("pz.r1", 3'b001, 6'd2);
    tick();
    check_run("pz.r2", 3'b001, 6'd1);
    tick();
    check_run("pz.r3", 3'b010, 6'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("pz.tail%0d.finish", i), 32'(finish), 0);
    end
    tick();
    check("pz.finish", 32'(finish), 1);
    $display("paused run complete");

    // 5: power off during RINSE remaining 2
    mode = 2'b00;
    press_start();
    for (int i = 0; i < 6; i++) tick();
    check_run("poff.before", 3'b010, 6'd2);
    power_key = 1'b1;
    tick();
    power_key = 1'b0;
    check("poff.power_led", 32'(power_led), 0);
    check("poff.finish", 32'(finish), 0);
    check("poff.pause", 32'(pause), 0);
    check_run("poff", 3'b000, 6'd0);
    tick();
    check("poff.finish2", 32'(finish), 0);
    $display("power off mid-run");

    // simultaneous power_key + start_pause in IDLE
    power_key = 1'b1;
    tick();
    power_key = 1'b0;
    check("both.pre_led", 32'(power_led), 1);
    power_key = 1'b1;
    start_pause = 1'b1;
    tick();
    power_key = 1'b0;
    start_pause = 1'b0;
    check("both.power_led", 32'(power_led), 0);
    check_run("both", 3'b000, 6'd0);
    $display("simultaneous power/start in idle");

`ifdef DOOR_LOCK_EN
    // 6: door lock
    power_key = 1'b1;
    tick();
    power_key = 1'b0;
    door_open = 1'b1;
    mode = 2'b11;
    press_start();
    check_run("door.idle_start", 3'b000, 6'd0);
    door_open = 1'b0;
    press_start();
    check_run("door.start", 3'b100, 6'd2);
    door_open = 1'b1;
    tick();
    check("door.forced", 32'(pause), 1);
    check_run("door.forced", 3'b100, 6'd2);
    press_start();
    check("door.held", 32'(pause), 1);
    door_open = 1'b0;
    tick();
    check("door.closed", 32'(pause), 1);
    check_run("door.closed", 3'b100, 6'd2);
    press_start();
    check("door.resume", 32'(pause), 0);
    tick();
    check_run("door.r1", 3'b100, 6'd1);
    tick();
    check("door.finish", 32'(finish), 1);
    $display("door lock sequence complete");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
Name: wash_sequencer

Overview:
Program sequencer for the washing-machine controller. It runs the wash → rinse → spin stages with a per-stage countdown and handles power on/off and start/pause. It drives power_led, pause and finish into the downstream beep/indicator stage (beep_alert). It runs on the same slow tick clock clk_n (1 Hz on board) and exposes the remaining time for the display stage.

Parameters:
WASH_T, 5, wash stage length in clk_n cycles (≥1)
RINSE_T, 3, rinse stage length in clk_n cycles (≥1)
SPIN_T, 2, spin stage length in clk_n cycles (≥1)
CNT_W, 6, width of remaining counter; must hold max(WASH_T,RINSE_T,SPIN_T)

Ports:
clk_n  in  1  tick clock; all state changes on posedge
rst  in  1  synchronous, active-high reset
power_key  in  1  single-cycle debounced pulse; toggles power
start_pause  in  1  single-cycle debounced pulse; start from idle / toggle pause while running
mode  in  2  program select, sampled only at start
power_led  out  1  1 = powered (all states except OFF)
pause  out  1  1 = running program frozen
finish  out  1  one-cycle pulse at program completion
busy  out  1  1 in WASH/RINSE/SPIN
stage  out  3  one-hot {spin,rinse,wash}; 000 when not running
remaining  out  CNT_W  cycles left in current stage; 0 when not running

Behaviour:
- All outputs registered. rst (sync, active-high) → state OFF; power_led=0, pause=0, finish=0, busy=0, stage=000, remaining=0. rst overrides all inputs.
- States: OFF, IDLE, WASH, RINSE, SPIN.
- OFF: power_key → IDLE, power_led=1. start_pause ignored.
- Any powered state: power_key → OFF next edge; pause, finish, stage and remaining cleared. Takes priority over start_pause in the same cycle.
- IDLE: start_pause → first stage of the selected mode, remaining loaded with that stage's T, pause=0.
- Mode sequences:
  - 00 = WASH→RINSE→SPIN
  - 01 = WASH→RINSE
  - 10 = RINSE→SPIN
  - 11 = SPIN only
  - mode changes during a run are ignored.
- Running, pause=0:
  - remaining>1 → decrement.
  - remaining==1 → next stage of the sequence with remaining=T of that stage, so each stage lasts exactly T cycles.
  - No next stage → IDLE, remaining=0, stage=000, finish=1 for exactly one cycle.
- Running: start_pause toggles pause. The edge that sets pause=1 does not decrement or transition, including when remaining==1. While pause=1 the counter is frozen. The edge that clears pause does not decrement; counting resumes on the following edge.
- finish is never asserted on power-off or on reset; it is never high for 2 consecutive cycles.
- pause is forced 0 in OFF and IDLE.
- busy = (stage != 000).

Optional Feature:
DOOR_LOCK_EN:
- Defined: adds input door_open (1 bit).
  - door_open=1 while running forces pause=1 on the next edge.
  - start_pause cannot clear pause while door_open=1.
  - start_pause from IDLE is ignored while door_open=1.
  - Closing the door does not auto-resume; a start_pause pulse is required.
- Undefined: no door_open port; behaviour as above.

Test Plan:
1. rst=1 two edges, then rst=0 → power_led=0, finish=0, remaining=0, stage=000.
2. power_key at edge p, mode=00, start_pause at edge k (k>p), defaults → WASH remaining 5,4,3,2,1 at k..k+4; RINSE 3,2,1 at k+5..k+7; SPIN 2,1 at k+8..k+9; at k+10 state IDLE with finish=1; finish=0 at k+11.
3. mode=11 → SPIN 2,1, then finish pulse 2 cycles after start. mode=10 → finish 5 cycles after start.
4. Pause during WASH at remaining=3, hold 4 cycles, resume pulse → remaining stays 3 for all held cycles and the resume edge; reaches RINSE exactly 3 edges after resume; finish 4+2 cycles later than case 2.
5. power_key during RINSE remaining=2 → power_led=0, stage=000, no finish pulse. Simultaneous power_key+start_pause in IDLE → OFF, no start.
6. DOOR_LOCK_EN: door_open=1 in SPIN → pause=1 next edge. start_pause with door open → pause stays 1. Close door, then start_pause → resumes from the frozen remaining.
